// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int DEF_LATENCY = 20;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;
endpackage

// File: rtl/arb_lat_counter.sv
// Access timer: counts BUSY cycles and flags the final one (count == LATENCY-1).
module arb_lat_counter #(
  parameter int LATENCY = 20,
  parameter int CW      = $clog2(LATENCY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CW'(LATENCY - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-side requests onto one fixed-latency memory port.
// Handshake: a requester holds its request until its ready pulses (one cycle, in DONE); inputs are sampled only at grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  input  logic          dread,
  input  logic          dwrite,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_e    state_o
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] PRE_TC = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  arb_state_e    state_q;
  grant_e        grant_q, last_grant_q, pick_d;
  logic          is_write_q, iready_q, dready_q, mem_en_q, mem_we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, irdata_q, drdata_q;
  logic [CW-1:0] cnt;
  logic          tc, dreq, contend, grant_now, busy, pre_tc;

  assign dreq      = dread | dwrite;
  assign contend   = ireq & dreq;
  assign grant_now = (state_q == ST_IDLE) && (ireq || dreq);
  assign busy      = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign pre_tc    = (LATENCY > 1) && (cnt == PRE_TC);

  // Round-robin only moves on contention, so a lone grant never shifts fairness.
  always_comb begin
    pick_d = GRANT_I;
    if (contend)   pick_d = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
    else if (dreq) pick_d = GRANT_D;
  end

  arb_lat_counter #(.LATENCY(LATENCY), .CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (grant_now),
    .enable_i (busy),
    .count_o  (cnt),
    .tc_o     (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_I;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
      iready_q     <= 1'b0;
      dready_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_now) begin
            grant_q  <= pick_d;
            mem_en_q <= 1'b1;
            if (contend) last_grant_q <= pick_d;
            if (pick_d == GRANT_D) begin
              addr_q     <= daddr;
              wdata_q    <= dwdata;
              is_write_q <= dwrite;
              mem_we_q   <= (LATENCY == 1) && dwrite;
              state_q    <= ST_BUSY_D;
            end else begin
              addr_q     <= iaddr;
              wdata_q    <= '0;
              is_write_q <= 1'b0;
              mem_we_q   <= 1'b0;
              state_q    <= ST_BUSY_I;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // mem_we is registered, so it is armed one cycle ahead of the final access cycle.
          if (tc) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!is_write_q) begin
              if (grant_q == GRANT_D) drdata_q <= mem_rdata;
              else                    irdata_q <= mem_rdata;
            end
            if (grant_q == GRANT_D) dready_q <= 1'b1;
            else                    iready_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (pre_tc) begin
            mem_we_q <= is_write_q;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign iready    = iready_q;
  assign dready    = dready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=20 instance for the main scenarios, LATENCY=1 instance for the short path.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 20;
  localparam int AW  = 32;
  localparam int DW  = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ireq, iready, dread, dwrite, dready, mem_en, mem_we;
  logic [AW-1:0] iaddr, daddr, mem_addr;
  logic [DW-1:0] irdata, dwdata, drdata, mem_wdata;
  logic [DW-1:0] mem_rdata = 32'hBAD0BAD0;
  arb_state_e    state;

  logic          b_reset, b_ireq, b_iready, b_dread, b_dwrite, b_dready, b_mem_en, b_mem_we;
  logic [AW-1:0] b_iaddr, b_daddr, b_mem_addr;
  logic [DW-1:0] b_irdata, b_dwdata, b_drdata, b_mem_wdata;
  logic [DW-1:0] b_mem_rdata = 32'hFFFFFFFF;
  arb_state_e    b_state;

  mem_arbiter #(.LATENCY(LAT), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
    .dread(dread), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dready(dready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_o(state)
  );

  mem_arbiter #(.LATENCY(1), .AW(AW), .DW(DW)) u_dut1 (
    .clk(clk), .reset(b_reset), .ireq(b_ireq), .iaddr(b_iaddr), .irdata(b_irdata), .iready(b_iready),
    .dread(b_dread), .dwrite(b_dwrite), .daddr(b_daddr), .dwdata(b_dwdata), .drdata(b_drdata),
    .dready(b_dready), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .state_o(b_state)
  );

  // scoreboard state
  int n_checks = 0;
  int n_errs   = 0;
  logic [2*DW:0]    exp_q[$];     // {side (1=data), irdata, drdata} expected at each ready pulse
  logic [AW+DW-1:0] exp_wr_q[$];  // {addr, wdata} expected at each mem_we pulse
  logic [DW-1:0]    m_ir = '0;
  logic [DW-1:0]    m_dr = '0;
  int               exp_burst = LAT;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], 16'hC0DE};
  endfunction

  // memory model: read data only valid on the final access cycle, checks burst stability and length
  int               en_cnt = 0;
  logic [AW+DW-1:0] burst_val = '0;
  always @(negedge clk) begin : mem_model
    logic [AW+DW-1:0] w;
    if (mem_en) begin
      en_cnt++;
      if (en_cnt == 1) burst_val = {mem_addr, mem_wdata};
      else chk("mem_stable", {mem_addr, mem_wdata}, burst_val);
      if (mem_we) begin
        chk("we_final_cycle", 64'(en_cnt), 64'(LAT));
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_we: addr=0x%0h wdata=0x%0h, no write outstanding", mem_addr, mem_wdata);
        end else begin
          w = exp_wr_q.pop_front();
          chk("we_addr", 64'(mem_addr), 64'(w[AW+DW-1:DW]));
          chk("we_wdata", 64'(mem_wdata), 64'(w[DW-1:0]));
        end
      end
      mem_rdata = (en_cnt == LAT) ? mem_fn(mem_addr) : 32'hBAD0BAD0;
    end else begin
      if (mem_we) chk("we_outside_access", 64'(mem_we), 64'd0);
      if (en_cnt > 0) chk("burst_len", 64'(en_cnt), 64'(exp_burst));
      en_cnt    = 0;
      mem_rdata = 32'hBAD0BAD0;
    end
  end

  // ready monitor: pops one expectation per ready pulse
  always @(negedge clk) begin : ready_mon
    logic [2*DW:0] e;
    if (iready || dready) begin
      chk("ready_onehot", 64'(iready & dready), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL unexpected_ready: iready=%0b dready=%0b, nothing outstanding", iready, dready);
      end else begin
        e = exp_q.pop_front();
        chk("ready_side", 64'(dready), 64'(e[2*DW]));
        chk("irdata", 64'(irdata), 64'(e[2*DW-1:DW]));
        chk("drdata", 64'(drdata), 64'(e[DW-1:0]));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, 64'({iready, dready, mem_en, mem_we}), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_irdata"}, 64'(irdata), 64'd0);
    chk({tag, "_drdata"}, 64'(drdata), 64'd0);
    chk({tag, "_state"}, 64'(state), 64'(ST_IDLE));
  endtask

  // driver: a single requester, held until its ready, optional mid-access address change
  task automatic lone_op(input bit side_d, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input bit chg);
    int n;
    bit seen;
    @(posedge clk); #1;
    if (side_d) begin
      dread = !wr; dwrite = wr; daddr = a; dwdata = wd;
      if (wr) exp_wr_q.push_back({a, wd});
      else    m_dr = exp_rd;
    end else begin
      ireq = 1'b1; iaddr = a; m_ir = exp_rd;
    end
    exp_q.push_back({side_d, m_ir, m_dr});
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (chg && n == 6) daddr = a + 32'h4;
      seen = side_d ? dready : iready;
    end
    chk("lone_latency", 64'(n - 1), 64'(LAT + 1));
    ireq = 1'b0; dread = 1'b0; dwrite = 1'b0;
  endtask

  // driver: both sides request in the same cycle, each drops on its own ready
  task automatic contend(input bit d_first, input logic [AW-1:0] ia, input logic [DW-1:0] iexp,
                         input logic [AW-1:0] da, input logic [DW-1:0] dexp);
    int n, t0, t1;
    bit i_done, d_done;
    @(posedge clk); #1;
    ireq = 1'b1; iaddr = ia; dread = 1'b1; daddr = da;
    if (d_first) begin
      m_dr = dexp; exp_q.push_back({1'b1, m_ir, m_dr});
      m_ir = iexp; exp_q.push_back({1'b0, m_ir, m_dr});
    end else begin
      m_ir = iexp; exp_q.push_back({1'b0, m_ir, m_dr});
      m_dr = dexp; exp_q.push_back({1'b1, m_ir, m_dr});
    end
    n = 0; t0 = -1; t1 = -1; i_done = 1'b0; d_done = 1'b0;
    while (!(i_done && d_done) && n < 200) begin
      @(negedge clk); n++;
      if (mem_en && t0 < 0) t0 = n;
      else if (mem_en && t1 < 0 && (i_done || d_done)) t1 = n;
      if (dready) begin dread = 1'b0; d_done = 1'b1; end
      if (iready) begin ireq = 1'b0; i_done = 1'b1; end
    end
    chk("contend_both_served", 64'({i_done, d_done}), 64'd3);
    chk("b2b_gap", 64'(t1 - t0), 64'(LAT + 2));
  endtask

  initial begin
    reset = 1'b0; ireq = 1'b0; iaddr = '0; dread = 1'b0; dwrite = 1'b0; daddr = '0; dwdata = '0;
    b_reset = 1'b0; b_ireq = 1'b0; b_iaddr = '0; b_dread = 1'b0; b_dwrite = 1'b0;
    b_daddr = '0; b_dwdata = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1; b_reset = 1'b1;

    lone_op(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);       // load
    lone_op(1'b1, 1'b1, 32'h80, 32'h12345678, 32'h0, 1'b0);       // store
    lone_op(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1);       // load, daddr moves mid-access
    lone_op(1'b0, 1'b0, 32'h100, 32'h0, 32'h0100C0DE, 1'b0);      // fetch
    contend(1'b1, 32'h300, 32'h0300C0DE, 32'h200, 32'h0200C0DE);  // first contention: data wins
    contend(1'b0, 32'h304, 32'h0304C0DE, 32'h204, 32'h0204C0DE);  // second: instruction wins

    // store aborted by reset during BUSY cycle 10
    @(posedge clk); #1;
    dwrite = 1'b1; daddr = 32'h80; dwdata = 32'hCAFEF00D; exp_burst = 10;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0; dwrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort");
    m_ir = '0; m_dr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    exp_burst = LAT;
    contend(1'b1, 32'h308, 32'h0308C0DE, 32'h208, 32'h0208C0DE);  // after reset: data wins again

    // LATENCY=1 with dread and dwrite both high: a write
    @(posedge clk); #1;
    b_dread = 1'b1; b_dwrite = 1'b1; b_daddr = 32'h10; b_dwdata = 32'h0BADCAFE;
    @(negedge clk);
    chk("l1_pre_grant_en", 64'(b_mem_en), 64'd0);
    @(negedge clk);
    chk("l1_busy_en_we", 64'({b_mem_en, b_mem_we}), 64'd3);
    chk("l1_busy_addr", 64'(b_mem_addr), 64'h10);
    chk("l1_busy_wdata", 64'(b_mem_wdata), 64'h0BADCAFE);
    b_dread = 1'b0; b_dwrite = 1'b0;
    @(negedge clk);
    chk("l1_done_strobes", 64'({b_mem_en, b_mem_we, b_iready, b_dready}), 64'd1);
    chk("l1_drdata_unchanged", 64'(b_drdata), 64'd0);
    @(negedge clk);
    chk("l1_ready_one_cycle", 64'(b_dready), 64'd0);

    repeat (5) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 20: cycles one main-memory access occupies; legal range 1..255.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 ireq  input  1  instruction-fetch read request; held until iready.
REQ-007 iaddr  input  AW  fetch address.
REQ-008 irdata  output  DW  fetch read data; valid while iready=1.
REQ-009 iready  output  1  one-cycle completion pulse for fetch.
REQ-010 dread  input  1  data-side load request (memread_m).
REQ-011 dwrite  input  1  data-side store request (memwrite_m).
REQ-012 daddr  input  AW  data-side address.
REQ-013 dwdata  input  DW  store data.
REQ-014 drdata  output  DW  load data; valid while dready=1.
REQ-015 dready  output  1  one-cycle completion pulse for data side (drives memready_m).
REQ-016 mem_en  output  1  memory access active.
REQ-017 mem_we  output  1  write commit strobe, final access cycle only.
REQ-018 mem_addr  output  AW  latched access address.
REQ-019 mem_wdata  output  DW  latched store data.
REQ-020 mem_rdata  input  DW  memory read data, valid on final access cycle.

Function
REQ-021 FSM SHALL have states IDLE, BUSY_I, BUSY_D, DONE.
REQ-022 IDLE: SHALL grant when a request is pending (ireq, or dread|dwrite); SHALL latch address, store data and op into registers; SHALL clear counter; next state BUSY_I or BUSY_D.
REQ-023 Arbitration: single requester wins; both pending -> round-robin on last_grant bit; data side wins on first contention after reset.
REQ-024 dread=dwrite=1 simultaneously SHALL be treated as a write.
REQ-025 BUSY_x: mem_en=1, mem_addr/mem_wdata SHALL be the latched values, stable for exactly LATENCY cycles; counter increments per cycle.
REQ-026 Final BUSY cycle (counter=LATENCY-1): mem_we=1 for writes only; reads capture mem_rdata into the grantee's rdata register; next state DONE.
REQ-027 DONE: exactly one of iready/dready SHALL be 1 for one cycle; mem_en=0; next state IDLE.
REQ-028 Latency: grant edge to ready pulse = LATENCY+1 cycles; back-to-back requests start LATENCY+2 cycles apart.
REQ-029 Inputs SHALL be sampled only at grant; changes or request drop during BUSY/DONE SHALL NOT abort or alter the transaction; ready still pulses.
REQ-030 irdata/drdata SHALL hold last captured value until next read for that side.
REQ-031 Counter width SHALL be $clog2(LATENCY+1); LATENCY=1 SHALL give one BUSY cycle.
REQ-032 Request arriving in DONE SHALL NOT be granted until the following IDLE cycle.

Reset
REQ-033 reset=0 at clk edge SHALL force IDLE, counter=0, last_grant=instruction (data wins next), iready=dready=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, irdata=drdata=0.
REQ-034 reset mid-BUSY SHALL abort: no mem_we pulse, no ready pulse, no rdata update.

Structure
REQ-035 Package mem_arb_pkg SHALL hold FSM state enum, grant-id encoding, and default LATENCY/AW/DW constants.
REQ-036 One sub-module arb_lat_counter (clear, enable, terminal-count output at LATENCY-1) SHALL implement the access timer.

Verification
REQ-037 Lone load daddr=0x40, mem_rdata=0xDEADBEEF, LATENCY=20 -> mem_en high 20 cycles, dready pulse cycle 21 after grant, drdata=0xDEADBEEF, mem_we never 1.
REQ-038 Lone store daddr=0x80, dwdata=0x12345678 -> single mem_we pulse on 20th BUSY cycle with mem_addr=0x80, mem_wdata=0x12345678; dready one cycle later.
REQ-039 ireq and dread asserted together, held -> data served first, then instruction; second contention after both re-request -> instruction first.
REQ-040 Change daddr 0x40->0x44 mid-BUSY -> mem_addr stays 0x40 throughout.
REQ-041 reset=0 on BUSY cycle 10 of a store -> no mem_we, no dready; all outputs zero next cycle.
REQ-042 LATENCY=1, dread and dwrite both 1, daddr=0x10 -> one BUSY cycle with mem_we=1, dready next cycle.
